// File: rtl/bus_gpio_port_if.sv
// rtl/bus_gpio_port_if.sv - data-bus port-block interface for bus_gpio_port
//
// Purpose: groups the word-addressed data-bus signals of one 512-word port block.
// Signals:
//   PortAddress  9  word address within the block (master drives)
//   WriteData   16  bus write data (master drives)
//   WriteEnable  1  write strobe, already qualified for this block (master drives)
//   ReadData    16  combinational read of the addressed register (slave drives)
interface bus_gpio_port_if;
  logic [8:0]  PortAddress;
  logic [15:0] WriteData;
  logic        WriteEnable;
  logic [15:0] ReadData;

  modport master (
    output PortAddress,
    output WriteData,
    output WriteEnable,
    input  ReadData
  );

  modport slave (
    input  PortAddress,
    input  WriteData,
    input  WriteEnable,
    output ReadData
  );
endinterface

// File: rtl/bus_gpio_port.sv
// rtl/bus_gpio_port.sv - GPIO port block: synchronised/debounced inputs, set/clr/toggle outputs, edge flags and irq
//
// Purpose: one 512-word data-bus port block serving switches, keys and LEDs.
// Ports:
//   Clock   in   system clock, rising edge
//   Reset   in   asynchronous active-high reset
//   bus     slave port of bus_gpio_port_if (PortAddress, WriteData, WriteEnable, ReadData)
//   PinIn   in   Width asynchronous external inputs
//   PinOut  out  Width registered outputs
//   Irq     out  registered OR of all EDGE flags
// Register map (PortAddress[3:0]; [8:4] alias):
//   0 IN, 1 OUT, 2 OUT_SET, 3 OUT_CLR, 4 OUT_TGL, 5 EDGE (W1C), 6 RISE_EN, 7 FALL_EN, 8 RAW, 9..15 zero
module bus_gpio_port #(
  parameter int               Width          = 10,
  parameter int               SyncStages     = 2,
  parameter int               DebounceCycles = 50000,
  parameter logic [Width-1:0] OutReset       = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  bus_gpio_port_if.slave   bus,
  input  logic [Width-1:0] PinIn,
  output logic [Width-1:0] PinOut,
  output logic             Irq
);

  localparam int CntW = (DebounceCycles > 0) ? $clog2(DebounceCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (DebounceCycles > 0) ? CntW'(DebounceCycles - 1) : '0;

  localparam logic [3:0] AddrIn     = 4'd0;
  localparam logic [3:0] AddrOut    = 4'd1;
  localparam logic [3:0] AddrOutSet = 4'd2;
  localparam logic [3:0] AddrOutClr = 4'd3;
  localparam logic [3:0] AddrOutTgl = 4'd4;
  localparam logic [3:0] AddrEdge   = 4'd5;
  localparam logic [3:0] AddrRiseEn = 4'd6;
  localparam logic [3:0] AddrFallEn = 4'd7;
  localparam logic [3:0] AddrRaw    = 4'd8;

  logic [3:0]       reg_sel;
  logic [Width-1:0] wdata;
  logic             wr;

  // Upper address bits alias and upper data bits beyond Width are ignored.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.PortAddress[8:4], bus.WriteData};

  assign reg_sel = bus.PortAddress[3:0];
  assign wdata   = bus.WriteData[Width-1:0];
  assign wr      = bus.WriteEnable;

  // Input synchroniser
  logic [Width-1:0] sync_q [SyncStages];
  logic [Width-1:0] raw;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int s = 0; s < SyncStages; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= PinIn;
      for (int s = 1; s < SyncStages; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign raw = sync_q[SyncStages-1];

  // Debounce: stable_d is the value stable_q takes on the coming edge.
  logic [Width-1:0] stable_q;
  logic [Width-1:0] stable_d;

  generate
    if (DebounceCycles == 0) begin : g_bypass
      // Load from the stage feeding raw so stable_q always equals raw and IN
      // keeps the plain synchroniser latency.
      assign stable_d = sync_q[SyncStages-2];
    end else begin : g_debounce
      logic [CntW-1:0] cnt_q [Width];
      logic [CntW-1:0] cnt_d [Width];

      always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < Width; i++) begin
          cnt_d[i] = '0;
          if (raw[i] != stable_q[i]) begin
            if (cnt_q[i] == CntLast) stable_d[i] = raw[i];
            else                     cnt_d[i]    = cnt_q[i] + 1'b1;
          end
        end
      end

      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          for (int i = 0; i < Width; i++) cnt_q[i] <= '0;
        end else begin
          for (int i = 0; i < Width; i++) cnt_q[i] <= cnt_d[i];
        end
      end
    end
  endgenerate

  // Registers and edge capture
  logic [Width-1:0] out_q;
  logic [Width-1:0] rise_en_q;
  logic [Width-1:0] fall_en_q;
  logic [Width-1:0] edge_q;
  logic             irq_q;
  logic [Width-1:0] edge_set;
  logic [Width-1:0] edge_clr;

  assign edge_set = (rise_en_q & stable_d & ~stable_q) |
                    (fall_en_q & ~stable_d & stable_q);
  assign edge_clr = (wr && reg_sel == AddrEdge) ? wdata : '0;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stable_q  <= '0;
      out_q     <= OutReset;
      rise_en_q <= '0;
      fall_en_q <= '0;
      edge_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      stable_q <= stable_d;
      // Set is OR-ed after the clear so a same-cycle new edge wins.
      edge_q   <= (edge_q & ~edge_clr) | edge_set;
      irq_q    <= |edge_q;
      if (wr) begin
        case (reg_sel)
          AddrOut:    out_q     <= wdata;
          AddrOutSet: out_q     <= out_q | wdata;
          AddrOutClr: out_q     <= out_q & ~wdata;
          AddrOutTgl: out_q     <= out_q ^ wdata;
          AddrRiseEn: rise_en_q <= wdata;
          AddrFallEn: fall_en_q <= wdata;
          default:    ;
        endcase
      end
    end
  end

  // Combinational readback
  always_comb begin
    bus.ReadData = '0;
    case (reg_sel)
      AddrIn:     bus.ReadData = 16'(stable_q);
      AddrOut,
      AddrOutSet,
      AddrOutClr,
      AddrOutTgl: bus.ReadData = 16'(out_q);
      AddrEdge:   bus.ReadData = 16'(edge_q);
      AddrRiseEn: bus.ReadData = 16'(rise_en_q);
      AddrFallEn: bus.ReadData = 16'(fall_en_q);
      AddrRaw:    bus.ReadData = 16'(raw);
      default:    bus.ReadData = '0;
    endcase
  end

  assign PinOut = out_q;
  assign Irq    = irq_q;

endmodule

// File: tb/tb_bus_gpio_port.sv
// tb/tb_bus_gpio_port.sv - self-checking bench for bus_gpio_port
module tb_bus_gpio_port;
  localparam int W  = 10;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam logic [W-1:0] OUT_RST = 10'h2A5;

  logic         clk;
  logic         rst;
  logic [W-1:0] pin_in;
  logic [W-1:0] pin_out;
  logic         irq;

  bus_gpio_port_if bus ();

  bus_gpio_port #(
    .Width(W), .SyncStages(SS), .DebounceCycles(DB), .OutReset(OUT_RST)
  ) dut (
    .Clock(clk), .Reset(rst), .bus(bus), .PinIn(pin_in), .PinOut(pin_out), .Irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [8:0] a, output logic [15:0] d);
    bus.PortAddress = a;
    #1;
    d = bus.ReadData;
  endtask

  // Call at a negedge; returns at the following negedge with the write done.
  task automatic wr(input logic [8:0] a, input logic [15:0] d);
    bus.PortAddress = a;
    bus.WriteData   = d;
    bus.WriteEnable = 1'b1;
    @(negedge clk);
    bus.WriteEnable = 1'b0;
  endtask

  // Reference model: IN follows a raw bit once it has held a new value for
  // DB consecutive samples; raw is PinIn delayed SS cycles.
  typedef logic [DB-1:0][W-1:0] win_t;
  logic [SS-1:0][W-1:0] m_ph;
  logic [DB-1:0][W-1:0] m_rh;
  logic [W-1:0] m_stab, m_out, m_rise, m_fall, m_edge;
  logic         m_irq;
  logic [W-1:0] m_raw, m_stab_n, m_set, m_clr;
  win_t         m_win;

  function automatic logic [W-1:0] deb_next(input win_t win, input logic [W-1:0] stab);
    logic [W-1:0] n = stab;
    for (int i = 0; i < W; i++) begin
      int ones = 0;
      for (int k = 0; k < DB; k++) if (win[k][i]) ones++;
      if (!stab[i] && ones == DB) n[i] = 1'b1;
      if (stab[i] && ones == 0)   n[i] = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [W-1:0] out_next(input logic [W-1:0] o, input logic we,
                                            input logic [3:0] a, input logic [W-1:0] d);
    if (!we) return o;
    case (a)
      4'd1: return d;
      4'd2: return o | d;
      4'd3: return o & ~d;
      4'd4: return o ^ d;
      default: return o;
    endcase
  endfunction

  function automatic logic [15:0] model_read(input logic [3:0] a);
    case (a)
      4'd0: return 16'(m_stab);
      4'd1, 4'd2, 4'd3, 4'd4: return 16'(m_out);
      4'd5: return 16'(m_edge);
      4'd6: return 16'(m_rise);
      4'd7: return 16'(m_fall);
      4'd8: return 16'(m_raw);
      default: return 16'h0000;
    endcase
  endfunction

  assign m_raw    = m_ph[SS-1];
  assign m_win    = {m_rh[DB-2:0], m_raw};
  assign m_stab_n = deb_next(m_win, m_stab);
  assign m_set    = (m_rise & m_stab_n & ~m_stab) | (m_fall & ~m_stab_n & m_stab);
  assign m_clr    = (bus.WriteEnable && bus.PortAddress[3:0] == 4'd5) ? bus.WriteData[W-1:0] : '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= '0; m_rh <= '0; m_stab <= '0; m_out <= OUT_RST;
      m_rise <= '0; m_fall <= '0; m_edge <= '0; m_irq <= 1'b0;
    end else begin
      m_ph   <= {m_ph[SS-2:0], pin_in};
      m_rh   <= m_win;
      m_stab <= m_stab_n;
      m_edge <= (m_edge & ~m_clr) | m_set;
      m_irq  <= |m_edge;
      m_out  <= out_next(m_out, bus.WriteEnable, bus.PortAddress[3:0], bus.WriteData[W-1:0]);
      if (bus.WriteEnable && bus.PortAddress[3:0] == 4'd6) m_rise <= bus.WriteData[W-1:0];
      if (bus.WriteEnable && bus.PortAddress[3:0] == 4'd7) m_fall <= bus.WriteData[W-1:0];
    end
  end

  typedef struct {
    logic         we;
    logic [8:0]   wa;
    logic [15:0]  wd;
    logic [8:0]   ra;
    logic [15:0]  erd;
    logic [W-1:0] eout;
  } row_t;

  row_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d, d2;
    int c;

    tbl.push_back('{1'b0, 9'd0,     16'h0000, 9'd0,  16'h0000, 10'h2A5});
    tbl.push_back('{1'b0, 9'd0,     16'h0000, 9'd5,  16'h0000, 10'h2A5});
    tbl.push_back('{1'b0, 9'd0,     16'h0000, 9'd6,  16'h0000, 10'h2A5});
    tbl.push_back('{1'b0, 9'd0,     16'h0000, 9'd7,  16'h0000, 10'h2A5});
    tbl.push_back('{1'b0, 9'd0,     16'h0000, 9'd1,  16'h02A5, 10'h2A5});
    tbl.push_back('{1'b1, 9'd2,     16'h000F, 9'd1,  16'h02AF, 10'h2AF});
    tbl.push_back('{1'b1, 9'd3,     16'h00A0, 9'd2,  16'h020F, 10'h20F});
    tbl.push_back('{1'b1, 9'd4,     16'h0300, 9'd4,  16'h010F, 10'h10F});
    tbl.push_back('{1'b1, 9'd1,     16'hFFFF, 9'd1,  16'h03FF, 10'h3FF});
    tbl.push_back('{1'b1, 9'h101,   16'h0055, 9'd1,  16'h0055, 10'h055});
    tbl.push_back('{1'b1, 9'd0,     16'hFFFF, 9'd0,  16'h0000, 10'h055});
    tbl.push_back('{1'b1, 9'd8,     16'hFFFF, 9'd8,  16'h0000, 10'h055});
    for (int a = 9; a < 16; a++)
      tbl.push_back('{1'b1, 9'(a),  16'hFFFF, 9'(a), 16'h0000, 10'h055});
    tbl.push_back('{1'b1, 9'd6,     16'hFFFF, 9'd6,  16'h03FF, 10'h055});
    tbl.push_back('{1'b1, 9'd6,     16'h0000, 9'd6,  16'h0000, 10'h055});
    tbl.push_back('{1'b1, 9'h1F3,   16'h00F0, 9'd3,  16'h0005, 10'h005});

    rst = 1'b1;
    pin_in = '0;
    bus.PortAddress = '0;
    bus.WriteData = '0;
    bus.WriteEnable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_pinout", 16'(pin_out), 16'(OUT_RST));
    check("reset_irq", 16'(irq), 16'h0);

    // Register table
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if (tbl[i].we) wr(tbl[i].wa, tbl[i].wd);
      rd(tbl[i].ra, d);
      check($sformatf("tbl%0d_rd", i), d, tbl[i].erd);
      check($sformatf("tbl%0d_out", i), 16'(pin_out), 16'(tbl[i].eout));
    end

    // Debounce latency on bit 0
    @(negedge clk);
    pin_in[0] = 1'b1;
    for (c = 1; c <= 7; c++) begin
      @(negedge clk);
      rd(9'd8, d);
      rd(9'd0, d2);
      check($sformatf("deb_raw_c%0d", c), 16'(d[0]), 16'(c >= 2));
      check($sformatf("deb_in_c%0d", c), 16'(d2[0]), 16'(c >= 6));
    end

    // 3-cycle glitch on bit 1
    begin
      logic raw_seen, in_seen;
      raw_seen = 1'b0;
      in_seen = 1'b0;
      pin_in[1] = 1'b1;
      for (c = 1; c <= 12; c++) begin
        @(negedge clk);
        if (c == 3) pin_in[1] = 1'b0;
        rd(9'd8, d);
        rd(9'd0, d2);
        if (d[1]) raw_seen = 1'b1;
        if (d2[1]) in_seen = 1'b1;
      end
      check("glitch_raw_seen", 16'(raw_seen), 16'h1);
      check("glitch_in_seen", 16'(in_seen), 16'h0);
    end

    // Edge capture
    pin_in = '0;
    repeat (10) @(negedge clk);
    wr(9'd6, 16'h0001);
    wr(9'd7, 16'h0002);
    pin_in = 10'h003;
    d = '0;
    for (c = 1; c <= 20; c++) begin
      @(negedge clk);
      rd(9'd5, d);
      if (d != 0) break;
    end
    check("rise_latency", 16'(c), 16'd6);
    check("edge_after_rise", d, 16'h0001);
    check("irq_lag0", 16'(irq), 16'h0);
    @(negedge clk);
    check("irq_lag1", 16'(irq), 16'h1);
    pin_in = 10'h000;
    for (c = 1; c <= 20; c++) begin
      @(negedge clk);
      rd(9'd5, d);
      if (d != 16'h0001) break;
    end
    check("fall_latency", 16'(c), 16'd6);
    check("edge_after_fall", d, 16'h0003);
    wr(9'd5, 16'h0001);
    rd(9'd5, d);
    check("w1c_bit0", d, 16'h0002);
    check("irq_after_w1c", 16'(irq), 16'h1);
    wr(9'd5, 16'h0002);
    rd(9'd5, d);
    check("w1c_all", d, 16'h0000);
    check("irq_deassert_lag", 16'(irq), 16'h1);
    @(negedge clk);
    check("irq_deassert", 16'(irq), 16'h0);

    // Same-cycle set and W1C on bit 0
    pin_in[0] = 1'b1;
    repeat (8) @(negedge clk);
    rd(9'd5, d);
    check("sim_pre_edge", d, 16'h0001);
    pin_in[0] = 1'b0;
    repeat (8) @(negedge clk);
    pin_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    wr(9'd5, 16'h0001);
    rd(9'd5, d);
    check("sim_edge_kept", d, 16'h0001);
    check("sim_irq_kept", 16'(irq), 16'h1);
    @(negedge clk);
    check("sim_irq_next", 16'(irq), 16'h1);
    wr(9'd5, 16'h0001);
    rd(9'd5, d);
    check("sim_clear_after", d, 16'h0000);

    // Reset two cycles into a debounce interval
    pin_in = '0;
    repeat (10) @(negedge clk);
    pin_in = 10'h004;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    rd(9'd0, d);
    check("rst_mid_in", d, 16'h0000);
    check("rst_mid_out", 16'(pin_out), 16'(OUT_RST));
    @(negedge clk);
    rst = 1'b0;
    for (c = 1; c <= 7; c++) begin
      @(negedge clk);
      rd(9'd8, d);
      rd(9'd0, d2);
      check($sformatf("rst_raw_c%0d", c), 16'(d[2]), 16'(c >= 2));
      check($sformatf("rst_in_c%0d", c), 16'(d2[2]), 16'(c >= 6));
    end

    // Randomised traffic against the reference model
    @(negedge clk);
    rst = 1'b1;
    pin_in = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if ($urandom_range(5) == 0) pin_in = pin_in ^ W'(1 << $urandom_range(W - 1));
      bus.WriteEnable = ($urandom_range(2) == 0);
      bus.PortAddress = 9'($urandom);
      bus.WriteData   = 16'($urandom);
      #1;
      check("rand_rd", bus.ReadData, model_read(bus.PortAddress[3:0]));
      check("rand_out", 16'(pin_out), 16'(m_out));
      check("rand_irq", 16'(irq), 16'(m_irq));
    end
    bus.WriteEnable = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bus_gpio_port.md
# bus_gpio_port

Parametrised general-purpose I/O peripheral occupying one 512-word port block on the data bus. It replaces the fixed input and output port pair with a single block that provides:
- synchronised and debounced inputs,
- an output register with set/clear/toggle writes,
- per-bit rising/falling edge capture with write-1-to-clear flags and an interrupt line.

Switches, keys and LEDs all attach through instances of this block.

## Interface
Parameters:
- Width, 10: number of I/O bits, 1..16; bits [15:Width] of every register read 0 and ignore writes.
- SyncStages, 2: input synchroniser depth, 2..4.
- DebounceCycles, 50000: consecutive stable cycles required before an input change is accepted (1 ms at 50 MHz); 0 bypasses the debouncer.
- OutReset, 0: reset value of the output register.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- PortAddress  in  9  word address within the block; only [3:0] is decoded, so [8:4] alias.
- WriteData  in  16  bus write data.
- WriteEnable  in  1  write strobe, already qualified for this block.
- ReadData  out  16  combinational read of the addressed register.
- PinIn  in  Width  asynchronous external inputs.
- PinOut  out  Width  registered outputs.
- Irq  out  1  OR of all EDGE flags, registered.

## Operation
Register map (PortAddress[3:0]):
- 0 IN: debounced input value. Read-only.
- 1 OUT: output register. Read/write.
- 2 OUT_SET: write sets OUT bits where WriteData=1. Read returns OUT.
- 3 OUT_CLR: write clears OUT bits where WriteData=1. Read returns OUT.
- 4 OUT_TGL: write inverts OUT bits where WriteData=1. Read returns OUT.
- 5 EDGE: captured edge flags. Writing 1 to a bit clears that flag (W1C).
- 6 RISE_EN: per-bit rising-edge capture enable. Read/write.
- 7 FALL_EN: per-bit falling-edge capture enable. Read/write.
- 8 RAW: synchroniser output, before debouncing. Read-only.
- 9..15: read 0; writes ignored.

Input path, per bit:
- Synchroniser: SyncStages flops.
- Debounce counter: width $clog2(DebounceCycles+1).
  - Counter clears whenever the synced value equals the stable value.
  - Otherwise the counter increments.
  - When the counter reaches DebounceCycles-1 while a difference is present, the stable bit takes the synced value and the counter clears.
  - A glitch shorter than DebounceCycles never reaches IN.

Edge capture:
- EDGE[i] is set on the same edge where stable[i] rises (if RISE_EN[i]) or falls (if FALL_EN[i]).
- Flags stay set until W1C.
- If a set and a W1C hit the same bit in the same cycle, the set wins.
- Irq is the registered |EDGE, so it lags EDGE by one cycle.

Reset values (asynchronous):
- PinOut = OutReset.
- EDGE, RISE_EN, FALL_EN, synchroniser flops, stable bits, counters and Irq = 0.
- Because the enables are 0 at reset, inputs that are high at reset never raise a spurious flag.

Mid-operation Reset: all state returns to reset values immediately, including counters that are partway through a debounce interval.

## Timing
- Writes take effect on the rising edge where WriteEnable=1. PinOut and readback reflect the new value from the following cycle.
- Reads are combinational from registered state, with zero wait states. This matches the existing input-port read timing.
- PinIn change to RAW: SyncStages cycles.
- PinIn change to IN: SyncStages + DebounceCycles cycles, or SyncStages when DebounceCycles=0. EDGE updates in the same cycle as IN.
- Irq is asserted one cycle after the first EDGE bit sets, and deasserts one cycle after the last flag clears.

## Test plan
Bench configuration: Width=10, SyncStages=2, DebounceCycles=4, OutReset=10'h2A5.

1. Reset and output writes:
   - After reset, PinOut=0x2A5 and reads of 0, 5, 6, 7 return 0.
   - Write 0x00F to addr 2, then 0x0A0 to addr 3, then 0x300 to addr 4.
   - PinOut sequence: 0x2AF, 0x20F, 0x10F.
   - Write 0xFFFF to addr 1 reads back 0x3FF.
2. Debounce:
   - PinIn[0] 0→1 held: RAW[0]=1 after 2 cycles, IN[0]=1 after 6 cycles.
   - A 3-cycle pulse on PinIn[1]: RAW shows it, IN[1] never changes.
3. Edge capture:
   - RISE_EN=0x001, FALL_EN=0x002; toggle bits 0 and 1 high, then low.
   - EDGE=0x001 after the rise, 0x003 after the fall of bit 1.
   - Irq asserts one cycle after EDGE[0].
   - Write 0x001 to addr 5 leaves EDGE=0x002.
4. Simultaneous set/clear:
   - Time a W1C of EDGE[0] on the exact cycle of a new rising edge on bit 0: EDGE[0] stays 1 and Irq stays 1.
5. Address aliasing and unused addresses:
   - Write to PortAddress 0x101 updates OUT.
   - Reads at addresses 9..15 return 0; writes to them change nothing.
6. Reset mid-debounce:
   - Assert Reset 2 cycles into a debounce interval: IN stays 0.
   - After release, the full SyncStages+DebounceCycles latency applies again.
